// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: CPU (master 0) and debug/DMA (master 1)
// share a single-cycle-handshake memory port.
module mem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_en,
    input  logic [3:0]  m0_we,
    input  logic [29:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_rdy,
    output logic [31:0] m0_rdata,
    input  logic        m1_en,
    input  logic [3:0]  m1_we,
    input  logic [29:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_rdy,
    output logic [31:0] m1_rdata,
    output logic        s_en,
    output logic [3:0]  s_we,
    output logic [29:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_rdy,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       last_served, last_nxt;
    logic [1:0] rd_sel, rd_sel_nxt;
    logic       done0, done1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_served <= 1'b1;
            rd_sel      <= 2'b00;
        end else begin
            state       <= state_nxt;
            last_served <= last_nxt;
            rd_sel      <= rd_sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last_served;
        s_en      = 1'b0;
        s_we      = 4'h0;
        s_addr    = 30'h0;
        s_wdata   = 32'h0;
        m0_rdy    = 1'b0;
        m1_rdy    = 1'b0;
        grant     = 2'b00;
        done0     = (state == G0) && m0_en && s_rdy;
        done1     = (state == G1) && m1_en && s_rdy;
        unique case (state)
            IDLE: begin
                if (m0_en && m1_en)
                    state_nxt = (FIXED_PRIO || last_served) ? G0 : G1;
                else if (m0_en)
                    state_nxt = G0;
                else if (m1_en)
                    state_nxt = G1;
            end
            G0: begin
                grant   = 2'b01;
                s_en    = m0_en;
                s_we    = m0_we;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
                m0_rdy  = s_rdy && m0_en;
                if (done0) begin
                    last_nxt  = 1'b0;
                    state_nxt = m1_en ? G1 : IDLE;
                end else if (!m0_en) begin
                    state_nxt = IDLE;
                end
            end
            G1: begin
                grant   = 2'b10;
                s_en    = m1_en;
                s_we    = m1_we;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                m1_rdy  = s_rdy && m1_en;
                if (done1) begin
                    last_nxt  = 1'b1;
                    state_nxt = m0_en ? G0 : IDLE;
                end else if (!m1_en) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read data lands one cycle after the completing rdy; steer it by owner.
    assign rd_sel_nxt = {done1 && (m1_we == 4'h0), done0 && (m0_we == 4'h0)};
    assign m0_rdata   = rd_sel[0] ? s_rdata : 32'h0;
    assign m1_rdata   = rd_sel[1] ? s_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin and fixed-priority
// instances driven by the same master/memory stimulus.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_en, m1_en, s_rdy;
    logic [3:0]  m0_we, m1_we;
    logic [29:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata, s_rdata;

    logic        a_m0_rdy, a_m1_rdy, a_s_en;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_s_wdata;
    logic [3:0]  a_s_we;
    logic [29:0] a_s_addr;
    logic [1:0]  a_grant;

    logic        b_m0_rdy, b_m1_rdy, b_s_en;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_s_wdata;
    logic [3:0]  b_s_we;
    logic [29:0] b_s_addr;
    logic [1:0]  b_grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .m0_en(m0_en), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdy(a_m0_rdy), .m0_rdata(a_m0_rdata),
        .m1_en(m1_en), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdy(a_m1_rdy), .m1_rdata(a_m1_rdata),
        .s_en(a_s_en), .s_we(a_s_we), .s_addr(a_s_addr),
        .s_wdata(a_s_wdata), .s_rdy(s_rdy), .s_rdata(s_rdata),
        .grant(a_grant)
    );

    mem_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .rst(rst),
        .m0_en(m0_en), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdy(b_m0_rdy), .m0_rdata(b_m0_rdata),
        .m1_en(m1_en), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdy(b_m1_rdy), .m1_rdata(b_m1_rdata),
        .s_en(b_s_en), .s_we(b_s_we), .s_addr(b_s_addr),
        .s_wdata(b_s_wdata), .s_rdy(s_rdy), .s_rdata(s_rdata),
        .grant(b_grant)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_en = 0; m1_en = 0; s_rdy = 0;
        m0_we = 0; m1_we = 0;
        m0_addr = 0; m1_addr = 0;
        m0_wdata = 0; m1_wdata = 0;
        s_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        idle_inputs();
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        #1;
        check("rst_grant", {30'h0, a_grant}, 32'h0);
        check("rst_s_en", {31'h0, a_s_en}, 32'h0);
        check("rst_m0_rdata", a_m0_rdata, 32'h0);

        // single m0 read
        @(negedge clk); rst = 1;
        @(negedge clk);
        m0_en = 1; m0_addr = 30'h100;
        #1;
        check("rd_arb_grant", {30'h0, a_grant}, 32'h0);
        check("rd_arb_s_en", {31'h0, a_s_en}, 32'h0);
        @(negedge clk);
        s_rdy = 1;
        #1;
        check("rd_grant", {30'h0, a_grant}, 32'h1);
        check("rd_s_en", {31'h0, a_s_en}, 32'h1);
        check("rd_s_addr", {2'b0, a_s_addr}, 32'h100);
        check("rd_m0_rdy", {31'h0, a_m0_rdy}, 32'h1);
        check("rd_m1_rdy", {31'h0, a_m1_rdy}, 32'h0);
        @(negedge clk);
        m0_en = 0; s_rdy = 0; s_rdata = 32'hDEADBEEF;
        #1;
        check("rd_m0_rdata", a_m0_rdata, 32'hDEADBEEF);
        check("rd_m1_rdata", a_m1_rdata, 32'h0);
        check("rd_idle", {30'h0, a_grant}, 32'h0);
        check("rd_rdy_once", {31'h0, a_m0_rdy}, 32'h0);
        @(negedge clk);
        #1;
        check("rd_rdata_clr", a_m0_rdata, 32'h0);

        // tie after an m0 service: rr picks m1, fixed picks m0
        @(negedge clk);
        m0_en = 1; m1_en = 1; s_rdata = 0;
        m0_addr = 30'h10; m1_addr = 30'h20;
        @(negedge clk);
        s_rdy = 1;
        #1;
        check("tie_rr_grant", {30'h0, a_grant}, 32'h2);
        check("tie_fp_grant", {30'h0, b_grant}, 32'h1);
        check("tie_fp_addr", {2'b0, b_s_addr}, 32'h10);
        check("tie_fp_m0_rdy", {31'h0, b_m0_rdy}, 32'h1);
        check("tie_rr_m1_rdy", {31'h0, a_m1_rdy}, 32'h1);
        @(negedge clk);
        #1;
        check("fp_next_grant", {30'h0, b_grant}, 32'h2);
        check("fp_next_m1_rdy", {31'h0, b_m1_rdy}, 32'h1);
        check("rr_next_grant", {30'h0, a_grant}, 32'h1);
        @(negedge clk);
        m0_en = 0; m1_en = 0; s_rdy = 0;
        #1;
        check("drop_s_en", {31'h0, a_s_en}, 32'h0);
        @(negedge clk);
        #1;
        check("drop_idle_rr", {30'h0, a_grant}, 32'h0);
        check("drop_idle_fp", {30'h0, b_grant}, 32'h0);

        // round-robin alternation from reset, s_rdy tied high
        do_reset();
        m0_en = 1; m1_en = 1; s_rdy = 1;
        m0_addr = 30'h111; m1_addr = 30'h222;
        #1;
        check("alt_arb", {30'h0, a_grant}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("alt_grant", {30'h0, a_grant},
                  (i % 2 == 0) ? 32'h1 : 32'h2);
            check("alt_addr", {2'b0, a_s_addr},
                  (i % 2 == 0) ? 32'h111 : 32'h222);
            check("alt_rdy", {30'h0, a_m1_rdy, a_m0_rdy},
                  (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);

        // stalled m1 write
        do_reset();
        m1_en = 1; m1_we = 4'h3; m1_addr = 30'h55;
        m1_wdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_rdy = (i == 3);
            #1;
            check("wr_grant", {30'h0, a_grant}, 32'h2);
            check("wr_s_en", {31'h0, a_s_en}, 32'h1);
            check("wr_s_we", {28'h0, a_s_we}, 32'h3);
            check("wr_s_addr", {2'b0, a_s_addr}, 32'h55);
            check("wr_s_wdata", a_s_wdata, 32'h1234_5678);
            check("wr_m1_rdy", {31'h0, a_m1_rdy}, (i == 3) ? 32'h1 : 32'h0);
        end
        @(negedge clk);
        idle_inputs();
        s_rdata = 32'hFFFF_FFFF;
        #1;
        check("wr_m1_rdata", a_m1_rdata, 32'h0);
        check("wr_m0_rdata", a_m0_rdata, 32'h0);
        check("wr_idle", {30'h0, a_grant}, 32'h0);

        // async reset mid-transaction in G1
        do_reset();
        m1_en = 1;
        @(negedge clk);
        #1;
        check("ar_pre_s_en", {31'h0, a_s_en}, 32'h1);
        check("ar_pre_grant", {30'h0, a_grant}, 32'h2);
        #1;
        rst = 0;
        m0_en = 1; s_rdy = 1;
        #1;
        check("ar_s_en", {31'h0, a_s_en}, 32'h0);
        check("ar_grant", {30'h0, a_grant}, 32'h0);
        check("ar_m1_rdy", {31'h0, a_m1_rdy}, 32'h0);
        @(negedge clk);
        rst = 1; s_rdy = 0;
        #1;
        check("ar_rel_grant", {30'h0, a_grant}, 32'h0);
        @(negedge clk);
        #1;
        check("ar_tie_m0", {30'h0, a_grant}, 32'h1);
        @(negedge clk);
        m1_en = 0; m0_en = 0;
        @(negedge clk);
        #1;
        check("ar_end_idle", {30'h0, a_grant}, 32'h0);

        // m0 abandons in G0, pending m1 then served
        @(negedge clk);
        m0_en = 1;
        @(negedge clk);
        m1_en = 1;
        #1;
        check("ab_grant", {30'h0, a_grant}, 32'h1);
        check("ab_m0_rdy", {31'h0, a_m0_rdy}, 32'h0);
        @(negedge clk);
        m0_en = 0;
        #1;
        check("ab_drop_grant", {30'h0, a_grant}, 32'h1);
        check("ab_drop_s_en", {31'h0, a_s_en}, 32'h0);
        @(negedge clk);
        #1;
        check("ab_idle", {30'h0, a_grant}, 32'h0);
        check("ab_no_rdy", {31'h0, a_m0_rdy}, 32'h0);
        @(negedge clk);
        #1;
        check("ab_m1_grant", {30'h0, a_grant}, 32'h2);
        check("ab_m1_s_en", {31'h0, a_s_en}, 32'h1);
        @(negedge clk);
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0; 0 = round-robin, 1 = master 0 wins every tie.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 m0_en, m1_en  in  1 each  request from master 0 (CPU) / master 1 (debug/DMA), held with its attributes until the matching rdy.
REQ-005 m0_we, m1_we  in  4 each  byte write enables; 4'h0 = read.
REQ-006 m0_addr, m1_addr  in  30 each  word address [31:2].
REQ-007 m0_wdata, m1_wdata  in  32 each  write data.
REQ-008 m0_rdy, m1_rdy  out  1 each  transaction-complete pulse to that master.
REQ-009 m0_rdata, m1_rdata  out  32 each  read data to that master.
REQ-010 s_en, s_we[3:0], s_addr[31:2], s_wdata[31:0]  out  memory-side request.
REQ-011 s_rdy  in  1  memory completes the current s_en request in the same cycle.
REQ-012 s_rdata  in  32  memory read data, valid the cycle after the completing s_rdy.
REQ-013 grant  out  2  one-hot current owner; 2'b00 = none.

Function
REQ-014 Three states: IDLE, G0, G1; grant = 00 / 01 / 10 respectively.
REQ-015 IDLE: s_en=0, s_we=0, s_addr=0, s_wdata=0, m0_rdy=m1_rdy=0.
REQ-016 IDLE with one request: next state grants that master.
REQ-017 IDLE with both requests: FIXED_PRIO=1 -> G0; FIXED_PRIO=0 -> master other than last_served.
REQ-018 Arbitration latency: exactly one cycle from en rising in IDLE to s_en rising.
REQ-019 Gx: s_en, s_we, s_addr, s_wdata driven combinationally from master x; mx_rdy = s_rdy & mx_en; other master's rdy = 0.
REQ-020 Completion = Gx & mx_en & s_rdy; on completion, last_served <= x.
REQ-021 On completion, if the other master's en is high, next state grants it directly (no IDLE bubble), in both priority modes; otherwise next state IDLE.
REQ-022 Gx with mx_en=0 and no completion (abandoned request): next state IDLE, no rdy issued.
REQ-023 Requests from the non-granted master are never forwarded and never lost; they wait while their en is held.
REQ-024 rd_sel (2-bit one-hot register): on a read completion (s_we==0) by x, set to bit x; otherwise cleared to 00 next cycle.
REQ-025 mN_rdata = s_rdata when rd_sel[N]=1, else 32'h0; read data appears exactly one cycle after the master's rdy.
REQ-026 Write completions leave rd_sel at 00; a write and the previous read's data return may share a cycle.
REQ-027 Round-robin starvation bound: with both masters requesting continuously, grants alternate 0,1,0,1.

Reset
REQ-028 rst=0 asynchronously forces state IDLE, grant=00, rd_sel=00, last_served=1 (master 0 wins the first tie).
REQ-029 All outputs take their IDLE values while rst=0, including mid-transaction; no rdy is issued for an interrupted request.
REQ-030 First arbitration occurs on the first rising edge with rst=1.

Verification
REQ-031 m0 read, addr 30'h100, s_rdy in the first grant cycle, s_rdata=32'hDEADBEEF -> m0_rdy pulse in cycle 2, m0_rdata=32'hDEADBEEF in cycle 3, m1_rdata=0.
REQ-032 Both request from reset, FIXED_PRIO=0, s_rdy tied 1 -> grant sequence 01,10,01,10; no IDLE cycles between grants.
REQ-033 FIXED_PRIO=1, both request in IDLE -> G0 first; m1 served directly after m0 completes.
REQ-034 m1 write, we=4'h3, wdata=32'h1234_5678, s_rdy held 0 for 3 cycles, then 1 -> s_* stable for 4 cycles, a single m1_rdy, rd_sel stays 00.
REQ-035 rst driven low during G1 with s_en=1 -> s_en=0 and grant=00 without waiting for clk; after release, m0 wins the first tie.
REQ-036 m0 drops en while in G0 before s_rdy -> IDLE the next cycle, no m0_rdy, and a pending m1 request is granted one cycle later.
